// File: rtl/cr_cddip_int_coalesce_pkg.sv
// Shared types, widths and threshold helper for the CDDIP interrupt coalescer.
package cr_cddip_int_coalesce_pkg;

  localparam int CNT_W = 8;
  localparam int TMR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ASSERT = 2'd2
  } coal_state_e;

  // Disabled coalescing, or a zero count threshold, both mean "interrupt on every completion".
  function automatic logic [CNT_W-1:0] eff_thr(input logic en, input logic [CNT_W-1:0] cnt);
    return (!en || cnt == '0) ? CNT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/cr_cddip_int_coalesce_if.sv
// Completion/error inputs, moderation config and host interrupt outputs of the coalescer.
interface cr_cddip_int_coalesce_if;
  import cr_cddip_int_coalesce_pkg::*;

  logic             cqe_exit;
  logic             cddip_int;
  logic             cfg_coal_en;
  logic [CNT_W-1:0] cfg_coal_cnt;
  logic [TMR_W-1:0] cfg_coal_tmr;
  logic             irq_ack;
  logic             host_irq;
  logic [CNT_W-1:0] irq_batch_cnt;
  logic             irq_cnt_ovf;
  logic             coal_busy;

  modport master (
    output cqe_exit, cddip_int, cfg_coal_en, cfg_coal_cnt, cfg_coal_tmr, irq_ack,
    input  host_irq, irq_batch_cnt, irq_cnt_ovf, coal_busy
  );

  modport slave (
    input  cqe_exit, cddip_int, cfg_coal_en, cfg_coal_cnt, cfg_coal_tmr, irq_ack,
    output host_irq, irq_batch_cnt, irq_cnt_ovf, coal_busy
  );

endinterface

// File: rtl/cr_cddip_int_coalesce.sv
// Batches completion pulses by count or timeout into one host interrupt; errors bypass batching.
module cr_cddip_int_coalesce
  import cr_cddip_int_coalesce_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  cr_cddip_int_coalesce_if.slave   bus
);

  coal_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] batch_q, batch_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             host_irq_q, host_irq_d;

  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] cnt_next;
  logic [TMR_W-1:0] tmr_next;
  logic             cnt_sat;
  logic             fire;

  assign thr = eff_thr(bus.cfg_coal_en, bus.cfg_coal_cnt);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    batch_d    = batch_q;
    fire       = 1'b0;
    cnt_sat    = (cnt_q == '1);
    cnt_next   = (bus.cqe_exit && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;
    tmr_next   = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.cqe_exit) begin
          tmr_d = '0;
          if (thr == CNT_W'(1)) begin
            batch_d = CNT_W'(1);
            cnt_d   = '0;
            state_d = ASSERT;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        fire = (cnt_next >= thr) ||
               ((bus.cfg_coal_tmr != '0) && (tmr_next >= bus.cfg_coal_tmr));
        if (fire) begin
          batch_d = cnt_next;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = ASSERT;
        end else begin
          cnt_d = cnt_next;
          tmr_d = tmr_next;
        end
      end
      ASSERT: begin
        // Events seen while the host is being interrupted seed the next batch.
        cnt_d = cnt_next;
        tmr_d = '0;
        if (bus.irq_ack) begin
          state_d = (cnt_next == '0) ? IDLE : ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase

    ovf_d      = bus.irq_ack ? 1'b0 : (ovf_q | (bus.cqe_exit && cnt_sat));
    err_d      = bus.cddip_int;
    host_irq_d = (state_d == ASSERT) | err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      batch_q    <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      host_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      batch_q    <= batch_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      host_irq_q <= host_irq_d;
    end
  end

  assign bus.host_irq      = host_irq_q;
  assign bus.irq_batch_cnt = batch_q;
  assign bus.irq_cnt_ovf   = ovf_q;
  assign bus.coal_busy     = (state_q != IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_cr_cddip_int_coalesce.sv
// Scenario bench for the interrupt coalescer; a scoreboard checks the batch count of every interrupt.
module tb_cr_cddip_int_coalesce;
  import cr_cddip_int_coalesce_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cr_cddip_int_coalesce_if bus ();

  cr_cddip_int_coalesce dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_q[$];
  bit               mon_en = 1'b1;
  logic             irq_prev = 1'b0;

  // Scoreboard: each rising edge of host_irq pops the expected batch size.
  always @(negedge clk) begin
    if (mon_en && bus.host_irq === 1'b1 && irq_prev !== 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_irq batch=%0d, no interrupt expected", bus.irq_batch_cnt);
      end else begin
        logic [CNT_W-1:0] want;
        want = exp_q.pop_front();
        if (bus.irq_batch_cnt !== want) begin
          n_err++;
          $display("FAIL sb_batch_cnt got %0d want %0d", bus.irq_batch_cnt, want);
        end
      end
    end
    irq_prev = bus.host_irq;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.cqe_exit = 1'b1;
    tick();
    bus.cqe_exit = 1'b0;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic cfg(input logic en, input int cnt, input int tmr);
    bus.cfg_coal_en  = en;
    bus.cfg_coal_cnt = CNT_W'(cnt);
    bus.cfg_coal_tmr = TMR_W'(tmr);
  endtask

  task automatic test_reset();
    bus.cqe_exit = 1'b0; bus.cddip_int = 1'b0; bus.irq_ack = 1'b0;
    cfg(1'b0, 0, 0);
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++; if (bus.host_irq !== 1'b0) begin n_err++; $display("FAIL rst_host_irq got %b want 0", bus.host_irq); end
    n_vec++; if (bus.irq_batch_cnt !== '0) begin n_err++; $display("FAIL rst_batch got %0d want 0", bus.irq_batch_cnt); end
    n_vec++; if (bus.irq_cnt_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", bus.irq_cnt_ovf); end
    n_vec++; if (bus.coal_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus.coal_busy); end
    rst_n = 1'b1;
    tick();
  endtask

  // Coalescing disabled overrides a nonzero count threshold.
  task automatic test_no_coalesce();
    cfg(1'b0, 4, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(CNT_W'(1));
      pulse();
      n_vec++; if (bus.host_irq !== 1'b1) begin n_err++; $display("FAIL nocoal_rise[%0d] got %b want 1", i, bus.host_irq); end
      repeat (2) tick();
      ack();
      n_vec++; if (bus.host_irq !== 1'b0) begin n_err++; $display("FAIL nocoal_fall[%0d] got %b want 0", i, bus.host_irq); end
      n_vec++; if (bus.coal_busy !== 1'b0) begin n_err++; $display("FAIL nocoal_busy[%0d] got %b want 0", i, bus.coal_busy); end
      repeat (8) tick();
    end
  endtask

  task automatic test_count_thr();
    cfg(1'b1, 4, 0);
    exp_q.push_back(CNT_W'(4));
    bus.cqe_exit = 1'b1;
    repeat (3) tick();
    n_vec++; if (bus.host_irq !== 1'b0) begin n_err++; $display("FAIL cnt_early got %b want 0", bus.host_irq); end
    tick();
    bus.cqe_exit = 1'b0;
    n_vec++; if (bus.host_irq !== 1'b1) begin n_err++; $display("FAIL cnt_rise got %b want 1", bus.host_irq); end
    repeat (2) tick();
    ack();
    n_vec++; if (bus.host_irq !== 1'b0) begin n_err++; $display("FAIL cnt_fall got %b want 0", bus.host_irq); end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    cfg(1'b1, 8, 20);
    exp_q.push_back(CNT_W'(2));
    pulse();
    pulse();
    repeat (18) tick();
    n_vec++; if (bus.host_irq !== 1'b0) begin n_err++; $display("FAIL tmr_early got %b want 0", bus.host_irq); end
    tick();
    n_vec++; if (bus.host_irq !== 1'b1) begin n_err++; $display("FAIL tmr_rise got %b want 1", bus.host_irq); end
    ack();
    repeat (3) tick();
  endtask

  // Events during ASSERT plus one coincident with the ack form a full batch that re-fires via ACCUM.
  task automatic test_back_to_back();
    cfg(1'b1, 4, 0);
    exp_q.push_back(CNT_W'(4));
    exp_q.push_back(CNT_W'(4));
    bus.cqe_exit = 1'b1;
    repeat (7) tick();
    bus.irq_ack = 1'b1;
    tick();
    bus.cqe_exit = 1'b0;
    bus.irq_ack  = 1'b0;
    n_vec++; if (bus.host_irq !== 1'b0) begin n_err++; $display("FAIL b2b_gap got %b want 0", bus.host_irq); end
    tick();
    n_vec++; if (bus.host_irq !== 1'b1) begin n_err++; $display("FAIL b2b_refire got %b want 1", bus.host_irq); end
    ack();
    n_vec++; if (bus.coal_busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy got %b want 0", bus.coal_busy); end
    repeat (3) tick();
  endtask

  task automatic test_thr_edges();
    cfg(1'b1, 0, 0);
    exp_q.push_back(CNT_W'(1));
    pulse();
    n_vec++; if (bus.host_irq !== 1'b1) begin n_err++; $display("FAIL thr0_rise got %b want 1", bus.host_irq); end
    ack();
    // Ack outside ASSERT changes nothing.
    ack();
    n_vec++; if (bus.coal_busy !== 1'b0) begin n_err++; $display("FAIL idle_ack_busy got %b want 0", bus.coal_busy); end
    cfg(1'b1, 10, 0);
    exp_q.push_back(CNT_W'(3));
    repeat (3) pulse();
    tick();
    n_vec++; if (bus.host_irq !== 1'b0) begin n_err++; $display("FAIL lower_wait got %b want 0", bus.host_irq); end
    bus.cfg_coal_cnt = CNT_W'(2);
    tick();
    n_vec++; if (bus.host_irq !== 1'b1) begin n_err++; $display("FAIL lower_fire got %b want 1", bus.host_irq); end
    ack();
    repeat (3) tick();
  endtask

  task automatic test_saturation();
    cfg(1'b1, 255, 0);
    exp_q.push_back(CNT_W'(255));
    bus.cqe_exit = 1'b1;
    repeat (255) tick();
    n_vec++; if (bus.host_irq !== 1'b1) begin n_err++; $display("FAIL sat_fire got %b want 1", bus.host_irq); end
    n_vec++; if (bus.irq_cnt_ovf !== 1'b0) begin n_err++; $display("FAIL sat_ovf_early got %b want 0", bus.irq_cnt_ovf); end
    repeat (300) tick();
    bus.cqe_exit = 1'b0;
    n_vec++; if (bus.irq_cnt_ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf_set got %b want 1", bus.irq_cnt_ovf); end
    exp_q.push_back(CNT_W'(255));
    ack();
    n_vec++; if (bus.irq_cnt_ovf !== 1'b0) begin n_err++; $display("FAIL sat_ovf_clr got %b want 0", bus.irq_cnt_ovf); end
    n_vec++; if (bus.host_irq !== 1'b0) begin n_err++; $display("FAIL sat_ack_fall got %b want 0", bus.host_irq); end
    tick();
    n_vec++; if (bus.host_irq !== 1'b1) begin n_err++; $display("FAIL sat_refire got %b want 1", bus.host_irq); end
    ack();
    repeat (3) tick();
  endtask

  task automatic test_err_and_reset();
    mon_en = 1'b0;
    bus.cddip_int = 1'b1;
    repeat (2) tick();
    n_vec++; if (bus.host_irq !== 1'b1) begin n_err++; $display("FAIL err_rise got %b want 1", bus.host_irq); end
    n_vec++; if (bus.coal_busy !== 1'b0) begin n_err++; $display("FAIL err_busy got %b want 0", bus.coal_busy); end
    ack();
    tick();
    n_vec++; if (bus.host_irq !== 1'b1) begin n_err++; $display("FAIL err_hold_ack got %b want 1", bus.host_irq); end
    bus.cddip_int = 1'b0;
    repeat (2) tick();
    n_vec++; if (bus.host_irq !== 1'b0) begin n_err++; $display("FAIL err_fall got %b want 0", bus.host_irq); end
    cfg(1'b1, 8, 0);
    repeat (2) pulse();
    bus.cddip_int = 1'b1;
    repeat (2) tick();
    n_vec++; if (bus.coal_busy !== 1'b1) begin n_err++; $display("FAIL accum_busy got %b want 1", bus.coal_busy); end
    rst_n = 1'b0;
    bus.cddip_int = 1'b0;
    tick();
    n_vec++; if (bus.host_irq !== 1'b0) begin n_err++; $display("FAIL mid_rst_host_irq got %b want 0", bus.host_irq); end
    n_vec++; if (bus.irq_batch_cnt !== '0) begin n_err++; $display("FAIL mid_rst_batch got %0d want 0", bus.irq_batch_cnt); end
    n_vec++; if (bus.coal_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", bus.coal_busy); end
    rst_n = 1'b1;
    repeat (2) tick();
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_no_coalesce();
    test_count_thr();
    test_timeout();
    test_back_to_back();
    test_thr_edges();
    test_saturation();
    test_err_and_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
